// File: rtl/dphy_clk_mon_pkg.sv
// rtl/dphy_clk_mon_pkg.sv - shared types, constants and width helper for dphy_clk_monitor
package dphy_clk_mon_pkg;

  typedef enum logic [1:0] {MON_IDLE, MON_LOST, MON_ACQUIRE, MON_LOCKED} mon_state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dphy_clk_mon_ch.sv
// rtl/dphy_clk_mon_ch.sv - single-channel clock presence monitor (sync, edge detect, absent timer, FSM)
// Optional per-channel loss counter under DPHY_CLK_MON_LOSS_CNT_EN.
module dphy_clk_mon_ch
  import dphy_clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int ABSENT_CYCLES = 200,
  parameter int PRESENT_EDGES = 3
) (
  input  logic                  ref_clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic                  clk_mon_i,
`ifdef DPHY_CLK_MON_LOSS_CNT_EN
  input  logic                  loss_cnt_clr_i,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o,
`endif
  output logic                  locked_next_o,
  output logic                  rst_o,
  output logic                  locked_o,
  output logic                  lost_o
);

  localparam int AW = cnt_width(ABSENT_CYCLES);
  localparam int EW = cnt_width(PRESENT_EDGES);
  localparam logic [AW-1:0] ABSENT_MAX = AW'(ABSENT_CYCLES);
  localparam logic [EW-1:0] EDGE_MAX   = EW'(PRESENT_EDGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [AW-1:0]          absent_cnt_q;
  logic [EW-1:0]          edge_cnt_q, edge_cnt_d, edge_inc;
  mon_state_t             state_q, state_d;
  logic                   edge_det, absent;

  // Both polarities of the monitored clock count as an edge.
  assign edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;
  assign absent   = (absent_cnt_q == ABSENT_MAX);
  assign edge_inc = (edge_cnt_q == EDGE_MAX) ? EDGE_MAX : edge_cnt_q + EW'(1);

  always_ff @(posedge ref_clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_mon_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge ref_clk_i) begin
    if (!rst_n_i) begin
      absent_cnt_q <= ABSENT_MAX;
    end else if (edge_det) begin
      absent_cnt_q <= '0;
    end else if (!absent) begin
      absent_cnt_q <= absent_cnt_q + AW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    if (!enable_i) begin
      state_d    = MON_IDLE;
      edge_cnt_d = '0;
    end else begin
      case (state_q)
        MON_IDLE: state_d = MON_LOST;
        MON_LOST: begin
          if (edge_det) begin
            edge_cnt_d = EW'(1);
            state_d    = (PRESENT_EDGES == 1) ? MON_LOCKED : MON_ACQUIRE;
          end
        end
        MON_ACQUIRE: begin
          if (edge_det) begin
            edge_cnt_d = edge_inc;
            if (edge_inc == EDGE_MAX) state_d = MON_LOCKED;
          end else if (absent) begin
            state_d    = MON_LOST;
            edge_cnt_d = '0;
          end
        end
        MON_LOCKED: begin
          if (!edge_det && absent) begin
            state_d    = MON_LOST;
            edge_cnt_d = '0;
          end
        end
        default: state_d = MON_IDLE;
      endcase
    end
  end

  assign locked_next_o = (state_d == MON_LOCKED);

  // Outputs decode the next state so they move with the state register.
  always_ff @(posedge ref_clk_i) begin
    if (!rst_n_i) begin
      state_q    <= MON_IDLE;
      edge_cnt_q <= '0;
      rst_o      <= 1'b1;
      locked_o   <= 1'b0;
      lost_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      rst_o      <= (state_d != MON_LOCKED);
      locked_o   <= (state_d == MON_LOCKED);
      lost_o     <= (state_q == MON_LOCKED) && (state_d == MON_LOST);
    end
  end

`ifdef DPHY_CLK_MON_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  always_ff @(posedge ref_clk_i) begin
    if (!rst_n_i || loss_cnt_clr_i) begin
      loss_cnt_q <= '0;
    end else if (lost_o && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  assign loss_cnt_o = loss_cnt_q;
`endif

endmodule

// File: rtl/dphy_clk_monitor.sv
// rtl/dphy_clk_monitor.sv - multi-channel D-PHY clock presence monitor with aggregate lock flags
// Define DPHY_CLK_MON_LOSS_CNT_EN to add per-channel saturating loss counters.
module dphy_clk_monitor
  import dphy_clk_mon_pkg::*;
#(
  parameter int CH_CNT        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int ABSENT_CYCLES = 200,
  parameter int PRESENT_EDGES = 3
) (
  input  logic                         ref_clk_i,
  input  logic                         rst_n_i,
  input  logic [CH_CNT-1:0]            enable_i,
  input  logic [CH_CNT-1:0]            clk_mon_i,
`ifdef DPHY_CLK_MON_LOSS_CNT_EN
  input  logic                         loss_cnt_clr_i,
  output logic [CH_CNT*LOSS_CNT_W-1:0] loss_cnt_o,
`endif
  output logic [CH_CNT-1:0]            rst_o,
  output logic [CH_CNT-1:0]            locked_o,
  output logic                         all_locked_o,
  output logic                         any_locked_o,
  output logic [CH_CNT-1:0]            lost_o
);

  logic [CH_CNT-1:0] locked_next;

  for (genvar ch = 0; ch < CH_CNT; ch++) begin : g_ch
    dphy_clk_mon_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .ABSENT_CYCLES(ABSENT_CYCLES),
      .PRESENT_EDGES(PRESENT_EDGES)
    ) u_ch (
      .ref_clk_i    (ref_clk_i),
      .rst_n_i      (rst_n_i),
      .enable_i     (enable_i[ch]),
      .clk_mon_i    (clk_mon_i[ch]),
`ifdef DPHY_CLK_MON_LOSS_CNT_EN
      .loss_cnt_clr_i(loss_cnt_clr_i),
      .loss_cnt_o   (loss_cnt_o[ch*LOSS_CNT_W +: LOSS_CNT_W]),
`endif
      .locked_next_o(locked_next[ch]),
      .rst_o        (rst_o[ch]),
      .locked_o     (locked_o[ch]),
      .lost_o       (lost_o[ch])
    );
  end

  // Aggregates use the next-state lock decode so they align with locked_o.
  always_ff @(posedge ref_clk_i) begin
    if (!rst_n_i) begin
      all_locked_o <= 1'b0;
      any_locked_o <= 1'b0;
    end else begin
      all_locked_o <= &locked_next;
      any_locked_o <= |locked_next;
    end
  end

endmodule

// File: doc/dphy_clk_monitor.md
Name: dphy_clk_monitor

Overview:
- Parametrised multi-channel successor to the single-lane D-PHY clock-presence detector.
- Samples CH_CNT free-running byte/lane clocks as data in the ref_clk_i domain and runs a per-channel IDLE/LOST/ACQUIRE/LOCKED state machine.
- Drives per-channel reset requests, lock status and loss-event pulses to the CSI-2 receive lanes and the top-level status logic.
- Adds configurable sync depth, thresholds, aggregate lock flags and loss reporting.

Parameters:
- CH_CNT, 4: number of monitored clocks/channels.
- SYNC_STAGES, 2: synchroniser depth per channel (>=2).
- ABSENT_CYCLES, 200: ref_clk cycles without an edge before a channel is declared absent (>=2).
- PRESENT_EDGES, 3: edges required in ACQUIRE before LOCKED (>=1).

Ports:
- ref_clk_i  in  1  sole clock. One clock; all logic on its rising edge.
- rst_n_i  in  1  reset, synchronous and active-low.
- enable_i  in  CH_CNT  per-channel monitor enable.
- clk_mon_i  in  CH_CNT  monitored clocks; asynchronous, treated as data.
- rst_o  out  CH_CNT  per-channel active-high reset request. High unless the channel is LOCKED.
- locked_o  out  CH_CNT  channel in LOCKED.
- all_locked_o  out  1  AND of locked_o.
- any_locked_o  out  1  OR of locked_o.
- lost_o  out  CH_CNT  one-cycle pulse on the LOCKED->LOST transition.

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - All states go to IDLE.
  - Absent counters load ABSENT_CYCLES, so channels start absent.
  - Edge counters clear to 0.
  - rst_o = all ones; locked_o, all_locked_o, any_locked_o, lost_o = 0.
  - Synchroniser flops clear to 0.
- Edge detection:
  - clk_mon_i passes through SYNC_STAGES flops plus one history flop.
  - edge = last sync stage != history flop. Both clock edges count.
  - Edge is visible SYNC_STAGES+1 cycles after an input transition.
- Absent counter (width $clog2(ABSENT_CYCLES+1)):
  - Clears to 0 on edge; otherwise saturating increment up to ABSENT_CYCLES.
  - absent = (count == ABSENT_CYCLES), registered value.
- State machine, per channel, evaluated every cycle. Priority is: enable, then edge, then absent.
  - Any state, enable_i low: next state IDLE; edge counter cleared; no lost_o pulse.
  - IDLE, enable_i high: go to LOST.
  - LOST, edge: go to ACQUIRE with edge counter = 1. If PRESENT_EDGES==1, go directly to LOCKED.
  - ACQUIRE, edge: increment the edge counter. When the incremented value == PRESENT_EDGES, go to LOCKED next cycle.
  - ACQUIRE, absent and no edge: go to LOST; edge counter cleared.
  - LOCKED, absent and no edge: go to LOST; lost_o pulses high for exactly that transition cycle + 1 (registered, one cycle wide).
  - An edge in the same cycle as absent wins: the counter clears and the state is held.
- Outputs:
  - rst_o, locked_o and lost_o are registered from the next-state decode, so they change in the same cycle the state register updates.
  - all_locked_o and any_locked_o are registered from locked_o next-state, with no extra latency versus locked_o.
- Edge counter saturates at PRESENT_EDGES; no wrap.
- Channels are fully independent; a loss on one never affects another.

Optional Feature:
- Macro DPHY_CLK_MON_LOSS_CNT_EN.
- Defined:
  - Adds input loss_cnt_clr_i (1), output loss_cnt_o (CH_CNT*8, channel n at bits [8n+7:8n]).
  - Each channel's 8-bit counter increments on its lost_o pulse and saturates at 255.
  - loss_cnt_clr_i clears all counters. Clear has priority over a same-cycle increment.
  - Counters reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package dphy_clk_mon_pkg holds:
  - typedef enum logic [1:0] {MON_IDLE, MON_LOST, MON_ACQUIRE, MON_LOCKED} mon_state_t.
  - Constant LOSS_CNT_W = 8.
  - Function for counter width.
- Sub-module dphy_clk_mon_ch contains the single-channel synchroniser, edge detect, absent counter, FSM and optional loss counter. It is generated CH_CNT times.
- The top level only does replication, aggregate flags and the optional port.

Test Plan:
- Test 1: CH_CNT=2, defaults, reset held 5 cycles -> rst_o=2'b11, locked_o=0 during and after reset with clk_mon_i static.
- Test 2: ch0 enabled, toggling every 4 ref cycles -> locked_o[0] rises after the 3rd detected edge, rst_o[0] falls the same cycle. ch1 stays rst_o=1; any_locked_o=1, all_locked_o=0.
- Test 3: ch0 locked, clk_mon_i[0] stopped -> lost_o[0] single pulse exactly 200 cycles after the last detected edge; rst_o[0]=1 from then. With the macro, loss_cnt_o[7:0]=1.
- Test 4: ch0 in ACQUIRE after 2 edges, stopped for 200 cycles -> back to LOST with no lost_o pulse. 3 new edges are then needed to lock.
- Test 5: locked channel, enable_i dropped -> IDLE, rst_o=1, no lost_o. Re-enable with toggling -> relocks after 3 edges.
- Test 6: edge arriving on the exact cycle the absent count reaches 200 -> stays LOCKED. With the macro, 256 forced losses -> loss_cnt_o saturates at 255; clr plus a same-cycle loss -> reads 0.
